cube_arbiter: RTL
=================

// Module: cube_arbiter
// PURPOSE
//   Shares one multi-cycle cube unit (y = a^3) between NREQ requesters.
//   Round-robin selection; sequences the unit through start/busy and returns
//   the result to the winning requester with a one-cycle done pulse.
//   Sits between the requesting datapaths and the single cube instance.
// PARAMETERS
//   NREQ     4    number of requesters (2..8); IDX_W = $clog2(NREQ) localparam
//   A_W      8    operand width
//   Y_W      24   result width, fixed at 3*A_W
//   TIMEOUT  64   watchdog limit in cycles (used only with CUBE_ARB_TIMEOUT_EN)
// PORTS
//   clk_i         in   1          clock
//   rst_i         in   1          reset: synchronous, active-high
//   req_i         in   NREQ       per-requester request level
//   a_bi          in   NREQ*A_W   operands; requester k uses [k*A_W +: A_W]
//   done_o        out  NREQ       one-hot, one-cycle result-valid pulse
//   y_bo          out  Y_W        result, valid while done_o != 0, held after
//   busy_o        out  1          controller not in IDLE
//   timeout_o     out  1          one-cycle watchdog pulse (0 without macro)
//   cube_start_o  out  1          start to cube unit, one cycle wide
//   cube_a_bo     out  A_W        operand to cube unit, latched at grant
//   cube_busy_i   in   1          cube unit busy
//   cube_y_bi     in   Y_W        cube unit result
// BEHAVIOUR
//   - Reset (rst_i=1 at edge): state IDLE, all outputs 0, rr pointer = 0.
//     Reset mid-operation aborts it: no done_o. Cube unit shares rst_i.
//   - States: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> RESP -> IDLE.
//   - IDLE: if req_i != 0, pick first set bit at or after pointer (wrapping);
//     latch idx and operand into cube_a_bo; go ISSUE. req_i sampled only here.
//   - ISSUE: cube_start_o=1 for exactly this cycle; go WAIT_BUSY.
//   - WAIT_BUSY: stay until cube_busy_i=1, then WAIT_DONE.
//   - WAIT_DONE: stay until cube_busy_i=0; latch cube_y_bi into y_bo; go RESP.
//   - RESP: done_o[idx]=1 one cycle; pointer = idx+1 mod NREQ; go IDLE.
//   - Latency req->done = 4 + cube busy-high cycles. Next grant earliest the
//     cycle after RESP (one IDLE cycle between jobs).
//   - Requester holds req_i and operand until its done_o; may drop req_i
//     in the cycle after done_o. A request withdrawn mid-job still
//     completes and pulses done_o (requester ignores it).
//   - Simultaneous requests: strictly round-robin; no requester waits more
//     than NREQ-1 jobs. Pointer wraps NREQ-1 -> 0.
//   - Width: y_bo = zero-extended copy of cube_y_bi; no arithmetic here.
// CONFIGURATION
//   CUBE_ARB_TIMEOUT_EN defined: cycle counter runs in WAIT_BUSY/WAIT_DONE;
//     on reaching TIMEOUT -> IDLE, timeout_o=1 one cycle, no done_o, pointer
//     advances past idx. Counter clears on every state entry.
//   Not defined: no counter, WAIT states wait forever, timeout_o tied 0.
// STRUCTURE
//   Package cube_arb_pkg: state enum typedef, A_W/Y_W defaults.
//   Sub-module cube_rr_pick: combinational round-robin priority picker
//   (req vector + pointer -> idx + valid). FSM and datapath in top.
// TESTING (bench instantiates real cube unit)
//   1 Single: req_i=0001, a=3 -> one cube_start_o, done_o=0001, y_bo=27.
//   2 All four req, a={255,128,2,3}, pointer 0 -> done order 0,1,2,3;
//     y_bo = 27, 8, 2097152, 16581375.
//   3 Fairness: req 0 and 2 held high continuously -> grants alternate
//     0,2,0,2; no consecutive grants to the same requester.
//   4 Reset in WAIT_DONE -> next cycle busy_o=0, done_o=0, cube_start_o=0;
//     new req then completes normally.
//   5 Withdrawn request: req_i[1] drops in WAIT_DONE -> done_o=0010 still.
//   6 With CUBE_ARB_TIMEOUT_EN, TIMEOUT=8, cube_busy_i forced 0 ->
//     timeout_o pulses 9 cycles after start, no done_o, back to IDLE.

Source files
------------

// File: rtl/cube_arb_pkg.sv
// Shared types and default widths for the cube arbiter slice.
// Used by cube_arbiter (top) and cube_rr_pick (round-robin picker).
package cube_arb_pkg;

    localparam int CUBE_A_W = 8;
    localparam int CUBE_Y_W = 3 * CUBE_A_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_RESP
    } arb_state_t;

endpackage

// File: rtl/cube_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr,
// wrapping past NREQ-1 back to 0.
module cube_rr_pick
    import cube_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // One extra bit so ptr + i cannot overflow before the modulo fold.
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // NOTE: every combinational output gets a default first, otherwise paths
    // that skip an assignment infer a latch.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(NREQ)) begin
                sum = sum - (IDX_W + 1)'(NREQ);
            end
            cand = sum[IDX_W-1:0];
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/cube_arbiter.sv
// Round-robin arbiter sharing one multi-cycle cube unit between NREQ requesters.
// Optional watchdog on the wait states is enabled by defining CUBE_ARB_TIMEOUT_EN.
module cube_arbiter
    import cube_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int A_W     = CUBE_A_W,
    parameter int Y_W     = 3 * A_W,
    parameter int TIMEOUT = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NREQ-1:0]     req_i,
    input  logic [NREQ*A_W-1:0] a_bi,
    output logic [NREQ-1:0]     done_o,
    output logic [Y_W-1:0]      y_bo,
    output logic                busy_o,
    output logic                timeout_o,
    output logic                cube_start_o,
    output logic [A_W-1:0]      cube_a_bo,
    input  logic                cube_busy_i,
    input  logic [Y_W-1:0]      cube_y_bi
);

    localparam int IDX_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || Y_W != 3 * A_W || TIMEOUT < 1) begin : g_bad_params
        $error("cube_arbiter: unsupported parameter combination");
    end

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic             grant;
    logic             finish;
    logic             wd_expired;

    cube_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_i),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE:     state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (cube_busy_i) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (!cube_busy_i) begin
                    finish  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        // A watchdog expiry abandons the job: no result, straight back to IDLE.
        if (wd_expired) begin
            finish  = 1'b0;
            state_d = ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q        <= '0;
            idx_q        <= '0;
            cube_a_bo    <= '0;
            cube_start_o <= 1'b0;
            done_o       <= '0;
            y_bo         <= '0;
        end else begin
            cube_start_o <= grant;
            done_o       <= '0;
            if (grant) begin
                idx_q     <= pick_idx;
                cube_a_bo <= a_bi[pick_idx*A_W +: A_W];
            end
            if (finish) begin
                done_o <= NREQ'(1) << idx_q;
                y_bo   <= cube_y_bi;
            end
            if (state_q == ST_RESP || wd_expired) begin
                ptr_q <= (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + 1'b1;
            end
        end
    end

    assign busy_o = (state_q != ST_IDLE);

`ifdef CUBE_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt_q;

    assign wd_expired = (state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE) &&
                        (wd_cnt_q == CNT_W'(TIMEOUT - 1));

    // Counter restarts on every state change, so WAIT_DONE gets its own budget.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt_q  <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= wd_expired;
            if (state_d != state_q) begin
                wd_cnt_q <= '0;
            end else if (state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end
        end
    end
`else
    assign wd_expired = 1'b0;
    assign timeout_o  = 1'b0;
`endif

endmodule
